// File: rtl/lbp_pkg.sv
// Shared definitions for the local-binary-pattern engine.
// Holds image geometry, the FSM state type and neighbour bit positions.
package lbp_pkg;

    localparam int IMG_W    = 128;
    localparam int ADDR_W   = 14;
    localparam int LAST_IDX = IMG_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        ADVANCE,
        DONE
    } state_e;

    // Bit position of each neighbour in the LBP code.
    localparam int G0 = 0;
    localparam int G1 = 1;
    localparam int G2 = 2;
    localparam int G3 = 3;
    localparam int G4 = 4;
    localparam int G5 = 5;
    localparam int G6 = 6;
    localparam int G7 = 7;

endpackage

// File: rtl/lbp_if.sv
// Memory-side bundle of the LBP engine: gray-image read port, result
// write port and finish flag. master = engine, slave = memory system.
interface lbp_if #(
    parameter int ADDR_W = 14
);
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [7:0]        gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;

    modport master (
        input  gray_ready,
        input  gray_data,
        output gray_req,
        output gray_addr,
        output lbp_valid,
        output lbp_addr,
        output lbp_data,
        output finish
    );

    modport slave (
        output gray_ready,
        output gray_data,
        input  gray_req,
        input  gray_addr,
        input  lbp_valid,
        input  lbp_addr,
        input  lbp_data,
        input  finish
    );
endinterface

// File: rtl/lbp_compare.sv
// Combinational LBP code: bit i set iff neighbour g_i >= centre.
// Ports: c_i centre pixel, g_i[7:0] neighbours, code_o 8-bit code.
module lbp_compare (
    input  logic [7:0]      c_i,
    input  logic [7:0][7:0] g_i,
    output logic [7:0]      code_o
);
    always_comb begin
        code_o = '0;
        for (int i = 0; i < 8; i++) begin
            code_o[i] = (g_i[i] >= c_i);
        end
    end
endmodule

// File: rtl/lbp.sv
// LBP engine: scans interior pixels with a sliding 3x3 window and writes codes.
// Ports: clk, reset (async active-low), bus (lbp_if.master: read/write/finish).
module lbp #(
    parameter int IMG_W  = lbp_pkg::IMG_W,
    parameter int ADDR_W = lbp_pkg::ADDR_W
) (
    input logic    clk,
    input logic    reset,
    lbp_if.master  bus
);
    import lbp_pkg::*;

    localparam int CW = ADDR_W / 2;
    // Last interior index keeps the same border margin for any image size.
    localparam logic [CW-1:0] LAST = CW'(IMG_W - lbp_pkg::IMG_W + LAST_IDX);

    state_e                 st_q, st_d;
    logic [CW-1:0]          r_q, r_d, k_q, k_d;
    logic [1:0]             ic_q, ic_d, ir_q, ir_d;
    logic                   req_q, req_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   val_q, val_d;
    logic [ADDR_W-1:0]      la_q, la_d;
    logic [7:0]             ld_q, ld_d;
    logic                   fin_q, fin_d;
    logic [2:0][2:0][7:0]   win_q, win_d;
    logic [7:0][7:0]        nbr;
    logic [7:0]             code;
    logic [CW-1:0]          row_a, col_a;

    // Window is indexed [col][row]; centre sits at [1][1].
    always_comb begin
        nbr     = '0;
        nbr[G0] = win_q[0][0];
        nbr[G1] = win_q[1][0];
        nbr[G2] = win_q[2][0];
        nbr[G3] = win_q[0][1];
        nbr[G4] = win_q[2][1];
        nbr[G5] = win_q[0][2];
        nbr[G6] = win_q[1][2];
        nbr[G7] = win_q[2][2];
    end

    lbp_compare u_cmp (
        .c_i    (win_q[1][1]),
        .g_i    (nbr),
        .code_o (code)
    );

    always_comb begin
        st_d   = st_q;
        r_d    = r_q;
        k_d    = k_q;
        ic_d   = ic_q;
        ir_d   = ir_q;
        req_d  = 1'b0;
        addr_d = addr_q;
        val_d  = 1'b0;
        la_d   = la_q;
        ld_d   = ld_q;
        fin_d  = fin_q;
        win_d  = win_q;
        case (st_q)
            IDLE: begin
                if (bus.gray_ready) begin
                    st_d  = FETCH;
                    req_d = 1'b1;
                    r_d   = CW'(1);
                    k_d   = CW'(1);
                    ic_d  = 2'd0;
                    ir_d  = 2'd0;
                end
            end
            FETCH: begin
                // (ic_q, ir_q) names the slot of the request issued last cycle.
                if (req_q) begin
                    win_d[ic_q][ir_q] = bus.gray_data;
                    if (ic_q == 2'd2 && ir_q == 2'd2) begin
                        st_d = WRITE;
                    end else begin
                        req_d = 1'b1;
                        if (ir_q == 2'd2) begin
                            ic_d = ic_q + 2'd1;
                            ir_d = 2'd0;
                        end else begin
                            ir_d = ir_q + 2'd1;
                        end
                    end
                end
            end
            WRITE: begin
                val_d = 1'b1;
                la_d  = {r_q, k_q};
                ld_d  = code;
                st_d  = ADVANCE;
            end
            ADVANCE: begin
                if (k_q == LAST) begin
                    if (r_q == LAST) begin
                        st_d  = DONE;
                        fin_d = 1'b1;
                    end else begin
                        st_d  = FETCH;
                        req_d = 1'b1;
                        r_d   = r_q + CW'(1);
                        k_d   = CW'(1);
                        ic_d  = 2'd0;
                        ir_d  = 2'd0;
                    end
                end else begin
                    st_d     = FETCH;
                    req_d    = 1'b1;
                    k_d      = k_q + CW'(1);
                    win_d[0] = win_q[1];
                    win_d[1] = win_q[2];
                    ic_d     = 2'd2;
                    ir_d     = 2'd0;
                end
            end
            DONE: begin
                st_d = DONE;
            end
            default: st_d = IDLE;
        endcase
        // Slot (ic, ir) lives at (r-1+ir, k-1+ic) relative to the new centre.
        row_a = r_d - CW'(1) + {{(CW-2){1'b0}}, ir_d};
        col_a = k_d - CW'(1) + {{(CW-2){1'b0}}, ic_d};
        if (req_d) begin
            addr_d = {row_a, col_a};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q   <= IDLE;
            r_q    <= '0;
            k_q    <= '0;
            ic_q   <= '0;
            ir_q   <= '0;
            req_q  <= 1'b0;
            addr_q <= '0;
            val_q  <= 1'b0;
            la_q   <= '0;
            ld_q   <= '0;
            fin_q  <= 1'b0;
            win_q  <= '0;
        end else begin
            st_q   <= st_d;
            r_q    <= r_d;
            k_q    <= k_d;
            ic_q   <= ic_d;
            ir_q   <= ir_d;
            req_q  <= req_d;
            addr_q <= addr_d;
            val_q  <= val_d;
            la_q   <= la_d;
            ld_q   <= ld_d;
            fin_q  <= fin_d;
            win_q  <= win_d;
        end
    end

    assign bus.gray_req  = req_q;
    assign bus.gray_addr = addr_q;
    assign bus.lbp_valid = val_q;
    assign bus.lbp_addr  = la_q;
    assign bus.lbp_data  = ld_q;
    assign bus.finish    = fin_q;

endmodule

// File: tb/tb_lbp.sv
// Self-checking bench for lbp on a reduced 16x16 image.
// Scoreboard of expected writes, directed image patterns, reset cases.
module tb_lbp;
    localparam int W      = 16;
    localparam int AW     = 8;
    localparam int CW     = AW / 2;
    localparam int N      = W - 2;
    localparam int NCODES = N * N;
    localparam int TMO    = 5000;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lbp_if #(.ADDR_W(AW)) bus ();

    lbp #(.IMG_W(W), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0]    img [W*W];
    logic [7:0]    res [W*W];
    exp_t          sbq [$];
    int            wr_cnt;
    int            first_addr;
    int            last_addr;
    int            checks = 0;
    int            fails = 0;

    // Image memory: data valid 1 time unit after the request edge.
    always @(posedge clk) begin
        #1;
        if (bus.gray_req === 1'b1) bus.gray_data = img[bus.gray_addr];
        else bus.gray_data = 'z;
    end

    // Result memory and scoreboard compare.
    always @(negedge clk) begin
        if (reset && bus.lbp_valid === 1'b1) begin
            exp_t e;
            checks++;
            if (sbq.size() == 0) begin
                fails++;
                $error("FAIL extra_write addr=%0d data=%h expected no write",
                       bus.lbp_addr, bus.lbp_data);
            end else begin
                e = sbq.pop_front();
                assert ({bus.lbp_addr, bus.lbp_data} === {e.a, e.d}) else begin
                    fails++;
                    $error("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                           bus.lbp_addr, bus.lbp_data, e.a, e.d);
                end
            end
            if (wr_cnt == 0) first_addr = int'(bus.lbp_addr);
            last_addr = int'(bus.lbp_addr);
            res[bus.lbp_addr] = bus.lbp_data;
            wr_cnt++;
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(int r, int k);
        logic [7:0] c;
        logic [7:0] g [8];
        logic [7:0] m;
        c    = img[r*W + k];
        g[0] = img[(r-1)*W + k-1];
        g[1] = img[(r-1)*W + k];
        g[2] = img[(r-1)*W + k+1];
        g[3] = img[r*W + k-1];
        g[4] = img[r*W + k+1];
        g[5] = img[(r+1)*W + k-1];
        g[6] = img[(r+1)*W + k];
        g[7] = img[(r+1)*W + k+1];
        for (int i = 0; i < 8; i++) m[i] = (g[i] >= c);
        return m;
    endfunction

    task automatic prepare();
        exp_t e;
        sbq.delete();
        wr_cnt = 0;
        first_addr = -1;
        last_addr = -1;
        for (int i = 0; i < W*W; i++) res[i] = 8'h00;
        for (int r = 1; r <= N; r++) begin
            for (int k = 1; k <= N; k++) begin
                e.a = AW'(r*W + k);
                e.d = model(r, k);
                sbq.push_back(e);
            end
        end
    endtask

    task automatic chk_outs_zero(string tag);
        chk(tag, {bus.gray_req, bus.gray_addr, bus.lbp_valid,
                  bus.lbp_addr, bus.lbp_data, bus.finish}, 32'h0);
    endtask

    task automatic start(int delay);
        bus.gray_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("req_before_ready", bus.gray_req, 1'b0);
        end
        bus.gray_ready = 1'b1;
    endtask

    task automatic finish_run(string tag);
        int n;
        int bad;
        n = 0;
        while (bus.finish !== 1'b1 && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finish"}, bus.finish, 1'b1);
        repeat (3) @(negedge clk);
        chk({tag, "_finish_held"}, bus.finish, 1'b1);
        chk({tag, "_writes"}, wr_cnt, NCODES);
        chk({tag, "_queue_left"}, sbq.size(), 0);
        bad = 0;
        for (int r = 0; r < W; r++) begin
            for (int k = 0; k < W; k++) begin
                if ((r == 0 || r == W-1 || k == 0 || k == W-1) && res[r*W+k] != 8'h00)
                    bad++;
            end
        end
        chk({tag, "_border_zero"}, bad, 0);
    endtask

    initial begin
        int n;
        bus.gray_ready = 1'b0;
        bus.gray_data = 'z;
        repeat (2) @(negedge clk);
        chk_outs_zero("reset_state");

        // Uniform image, delayed gray_ready.
        for (int i = 0; i < W*W; i++) img[i] = 8'h80;
        prepare();
        start(50);
        finish_run("uniform");
        chk("uniform_first", res[W+1], 8'hFF);
        chk("uniform_last", res[N*W+N], 8'hFF);

        // One hand-built window centred at (6,6).
        for (int i = 0; i < W*W; i++) img[i] = 8'h00;
        img[6*W+6] = 8'd50;
        img[5*W+5] = 8'd10; img[5*W+6] = 8'd60; img[5*W+7] = 8'd50;
        img[6*W+5] = 8'd40; img[6*W+7] = 8'd70;
        img[7*W+5] = 8'd20; img[7*W+6] = 8'd90; img[7*W+7] = 8'd30;
        prepare();
        start(0);
        finish_run("window");
        chk("window_code", res[6*W+6], 8'h56);

        // Isolated bright pixel at (5,5).
        for (int i = 0; i < W*W; i++) img[i] = 8'h00;
        img[5*W+5] = 8'hFF;
        prepare();
        start(0);
        finish_run("isolated");
        chk("isolated_centre", res[5*W+5], 8'h00);
        chk("isolated_far", res[10*W+10], 8'hFF);

        // Horizontal ramp.
        for (int r = 0; r < W; r++)
            for (int k = 0; k < W; k++) img[r*W+k] = 8'(k*2);
        prepare();
        start(0);
        finish_run("ramp");
        chk("ramp_first_code", res[W+1], 8'hD6);
        chk("ramp_last_code", res[N*W+N], 8'hD6);
        chk("ramp_first_addr", first_addr, W+1);
        chk("ramp_last_addr", last_addr, N*W+N);

        // Random image, aborted mid-row 8 by reset, then rerun.
        for (int i = 0; i < W*W; i++) img[i] = 8'($urandom_range(0, 3));
        prepare();
        start(0);
        n = 0;
        while (!(bus.lbp_valid === 1'b1 && int'(bus.lbp_addr[AW-1:CW]) == 8) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_row", n < TMO, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_outs_zero("abort_outs_now");
        repeat (3) @(negedge clk);
        chk_outs_zero("abort_outs_held");
        prepare();
        start(0);
        finish_run("rerun");
        chk("rerun_first_addr", first_addr, W+1);
        chk("rerun_last_addr", last_addr, N*W+N);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
